// File: rtl/serial_port_pkg.sv
// Shared constants and types for the memory-mapped 8N1 serial port.
package serial_port_pkg;

  // Register offsets within the 16-byte window
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_DIV_LO = 4'h2;
  localparam logic [3:0] REG_DIV_HI = 4'h3;

  // STATUS bit positions
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  // Shortest usable bit period; the RX mid-bit sample needs period/2 >= 2
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // Bit period actually used for a frame: max(DIV, MIN_DIV)
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO, 8-bit wide, 2**DEPTH_LOG2 entries.
// Pop on empty is ignored; push on full is accepted only if a pop frees a slot.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_port.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable divisor, sticky errors.
// Each frame latches its own bit period at start, so DIV writes never
// disturb a frame already on the wire.
module serial_port
  import serial_port_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp_cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] di,
  output logic [7:0] sp_do,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  logic        wr, rd, stat_rd;
  logic [15:0] div;
  logic        rx_overrun, frame_err;
  logic [7:0]  status, rd_data;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_dout, tx_shift;
  logic [15:0] tx_per, tx_cnt;
  logic [2:0]  tx_bit;
  logic        tx_tick;
  tx_state_t   tx_state, tx_next;

  logic        rx_s1, rx_s2, rx_prev, rx_fall;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_dout, rx_shift;
  logic [15:0] rx_per, rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_tick, rx_half, ovr_ev, ferr_ev;
  rx_state_t   rx_state, rx_next;

  assign wr      = sp_cs & rw;
  assign rd      = sp_cs & ~rw;
  assign stat_rd = rd & (addr == REG_STATUS);
  assign tx_push = wr & (addr == REG_DATA) & ~tx_full;
  assign rx_pop  = rd & (addr == REG_DATA) & ~rx_empty;
  assign irq     = ~rx_empty;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .din(di), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .dout(tx_dout)
  );

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .dout(rx_dout)
  );

  // STATUS register image
  always_comb begin
    status                = '0;
    status[ST_RX_AVAIL]   = ~rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_IDLE]    = tx_empty & (tx_state == TX_IDLE);
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  // Read data mux; empty DATA reads return zero
  always_comb begin
    rd_data = 8'h00;
    case (addr)
      REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: rd_data = status;
      REG_DIV_LO: rd_data = div[7:0];
      REG_DIV_HI: rd_data = div[15:8];
      default:    rd_data = 8'h00;
    endcase
  end

  // CPU-side state: divisor, registered read data, sticky flags.
  // A new error event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= DIV_RESET;
      sp_do      <= 8'h00;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr && addr == REG_DIV_LO) div[7:0]  <= di;
      if (wr && addr == REG_DIV_HI) div[15:8] <= di;
      if (rd) sp_do <= rd_data;
      rx_overrun <= ovr_ev  | (rx_overrun & ~stat_rd);
      frame_err  <= ferr_ev | (frame_err  & ~stat_rd);
    end
  end

  // ---------------- transmitter ----------------
  assign tx_tick = (tx_cnt == tx_per - 16'd1);

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state; STOP chains straight into START when more data waits
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
                  else tx_next = TX_IDLE;
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX datapath; txd is registered, so the pin lags the state by one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= '0;
      tx_per   <= MIN_DIV;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      if (tx_pop) begin
        tx_shift <= tx_dout;
        tx_per   <= eff_div(div);
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == TX_DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
      txd <= (tx_state == TX_START) ? 1'b0 :
             (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    end
  end

  // ---------------- receiver ----------------
  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == rx_per - 16'd1);
  assign rx_half = (rx_cnt == (rx_per >> 1) - 16'd1);

  // Two-flop synchronizer plus previous-sample for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state, FIFO push and error events
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    ovr_ev  = 1'b0;
    ferr_ev = 1'b0;
    case (rx_state)
      RX_IDLE:      if (rx_fall) rx_next = RX_START;
      RX_START:     if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) begin
                      if (rx_s2) begin
                        rx_next = RX_IDLE;
                        if (rx_full) ovr_ev  = 1'b1;
                        else         rx_push = 1'b1;
                      end else begin
                        ferr_ev = 1'b1;
                        rx_next = RX_WAIT_HIGH;
                      end
                    end
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: period latched at the falling edge, LSB-first shift-in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_per   <= MIN_DIV;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) rx_per <= eff_div(div);
        end
        RX_START: rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
        RX_DATA, RX_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Randomized scoreboard bench for serial_port. The model is a timeline of
// TX frame slots plus a byte queue for RX; monitors compare read data and
// decoded txd frames against queued expectations.
module tb_serial_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sp_cs = 1'b0, rw = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] di = 8'h00;
  logic [7:0] sp_do;
  logic       txd, irq;
  logic       rxd = 1'b1;

  serial_port dut (
    .clk(clk), .reset(reset), .sp_cs(sp_cs), .rw(rw), .addr(addr),
    .di(di), .sp_do(sp_do), .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] b; int per; int fall; } txe_t;
  typedef struct { logic [3:0] a; logic [7:0] d; } rde_t;

  txe_t        tx_q[$];      // frames expected on txd
  rde_t        rd_q[$];      // expected read data
  int          pop_times[$]; // edge at which each accepted TX byte leaves the FIFO
  int          last_end = 0; // edge at which the last scheduled frame finishes
  int          last_fall = 0;
  logic [7:0]  rxq[$];       // bytes the RX FIFO should hold
  logic        ovr_m = 1'b0, ferr_m = 1'b0;
  logic [15:0] div_m = 16'd434;
  bit          tx_mon_off = 1'b0;

  function automatic int per_of(input logic [15:0] d);
    return (d < 16'd4) ? 4 : int'(d);
  endfunction

  // TX FIFO occupancy just before edge c
  function automatic int tx_occ(input int c);
    int n = 0;
    foreach (pop_times[i]) if (pop_times[i] >= c) n++;
    return n;
  endfunction

  function automatic logic [7:0] status_exp(input int c);
    return {3'b000, ferr_m, ovr_m, (c > last_end), (tx_occ(c) >= 4), (rxq.size() > 0)};
  endfunction

  // ---------------- bus driver (call just after a negedge) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    int c, p, per;
    txe_t e;
    c = cyc + 1;
    if (a == 4'h0) begin
      if (tx_occ(c) < 4) begin
        per = per_of(div_m);
        p = (last_end > c + 1) ? last_end : c + 1;
        pop_times.push_back(p);
        last_end  = p + 10 * per;
        last_fall = p + 1;
        if (!tx_mon_off) begin e.b = d; e.per = per; e.fall = p + 1; tx_q.push_back(e); end
      end
    end else if (a == 4'h2) div_m[7:0] = d;
    else if (a == 4'h3) div_m[15:8] = d;
    sp_cs = 1'b1; rw = 1'b1; addr = a; di = d;
    @(negedge clk);
    sp_cs = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    rde_t e;
    int c;
    c = cyc + 1;
    e.a = a;
    case (a)
      4'h0: e.d = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      4'h1: begin e.d = status_exp(c); ovr_m = 1'b0; ferr_m = 1'b0; end
      4'h2: e.d = div_m[7:0];
      4'h3: e.d = div_m[15:8];
      default: e.d = 8'h00;
    endcase
    rd_q.push_back(e);
    sp_cs = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    sp_cs = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(4'h2, d[7:0]);
    bus_write(4'h3, d[15:8]);
  endtask

  task automatic wait_tx_done();
    while (cyc <= last_end + 10) @(negedge clk);
  endtask

  // Drive one 8N1 frame on rxd; stop=0 makes a framing error
  task automatic send_rx(input logic [7:0] b, input int per, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin rxd = fr[k]; repeat (per) @(negedge clk); end
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    if (stop) begin
      if (rxq.size() < 4) rxq.push_back(b); else ovr_m = 1'b1;
    end else ferr_m = 1'b1;
  endtask

  // ---------------- read-data monitor ----------------
  logic rd_flag = 1'b0;
  rde_t rd_e;
  always @(posedge clk) rd_flag <= sp_cs & ~rw & ~reset;
  always @(negedge clk) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) chk("read_unexpected", 1, 0);
      else begin
        rd_e = rd_q.pop_front();
        chk($sformatf("read_a%0h", rd_e.a), sp_do, rd_e.d);
      end
    end
  end

  // ---------------- txd frame monitor ----------------
  initial begin : tx_mon
    txe_t e;
    logic [9:0] fr;
    int guard;
    forever begin
      @(negedge clk);
      if (!tx_mon_off && !reset && txd === 1'b0) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_frame", 1, 0);
          guard = 0;
          while (txd !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        end else begin
          e = tx_q.pop_front();
          chk("tx_start_cycle", cyc, e.fall);
          repeat (e.per / 2) @(negedge clk);
          fr[0] = txd;
          for (int k = 1; k < 10; k++) begin repeat (e.per) @(negedge clk); fr[k] = txd; end
          chk("tx_frame", {22'd0, fr}, {22'd0, 1'b1, e.b, 1'b0});
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, d, nb;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("reset_txd", txd, 1);
    chk("reset_irq", irq, 0);
    chk("reset_sp_do", sp_do, 8'h00);
    bus_read(4'h1);
    bus_read(4'h2);
    bus_read(4'h3);

    // single TX frame at 8 clocks/bit
    set_div(16'd8);
    bus_write(4'h0, 8'hA5);
    bus_read(4'h1);
    wait_tx_done();
    bus_read(4'h1);

    // five writes while busy: fifth dropped, frames back-to-back
    bus_write(4'h0, 8'h11);
    while (cyc < last_fall) @(negedge clk);
    for (int i = 0; i < 5; i++) bus_write(4'h0, 8'($urandom));
    bus_read(4'h1);
    wait_tx_done();

    // single RX frame
    send_rx(8'h3C, 8, 1'b1);
    chk("irq_rise", irq, 1);
    bus_read(4'h0);
    chk("irq_fall", irq, 0);

    // overrun: five frames, no reads
    for (int i = 0; i < 5; i++) send_rx(8'($urandom), 8, 1'b1);
    bus_read(4'h1);
    bus_read(4'h1);
    for (int i = 0; i < 5; i++) bus_read(4'h0);

    // framing error, then a short glitch
    send_rx(8'($urandom), 8, 1'b0);
    chk("ferr_no_push", irq, 0);
    bus_read(4'h1);
    rxd = 1'b0; repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_push", irq, 0);
    bus_read(4'h1);

    // randomized TX rounds, including divisors below the minimum
    for (int r = 0; r < 5; r++) begin
      d = (r == 0) ? 0 : int'($urandom_range(1, 12));
      set_div(16'(d));
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        bus_write(4'h0, 8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 2) == 0) bus_read(4'h1);
      end
      wait_tx_done();
      bus_read(4'h1);
    end

    // randomized RX rounds
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(8, 14);
      set_div(16'(d));
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        send_rx(b, d, $urandom_range(0, 4) != 0);
        if ($urandom_range(0, 1) == 0) bus_read(4'h1);
      end
      bus_read(4'h1);
      for (int i = 0; i <= nb; i++) bus_read(4'h0);
    end

    // unmapped offsets read zero and ignore writes
    bus_write(4'h9, 8'hFF);
    bus_read(4'h9);
    bus_read(4'h2);

    // reset in the middle of TX and RX frames
    set_div(16'd8);
    send_rx(8'h5A, 8, 1'b1);
    chk("pre_reset_irq", irq, 1);
    tx_mon_off = 1'b1;
    bus_write(4'h0, 8'h00);
    bus_write(4'h0, 8'h00);
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    chk("midframe_txd_low", txd, 0);
    reset = 1'b1;
    #1;
    chk("reset_forces_txd", txd, 1);
    chk("reset_clears_irq", irq, 0);
    rxd = 1'b1;
    rxq.delete(); pop_times.delete();
    last_end = 0; ovr_m = 1'b0; ferr_m = 1'b0; div_m = 16'd434;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tx_mon_off = 1'b0;
    bus_read(4'h1);
    bus_read(4'h0);
    bus_read(4'h2);
    repeat (200) @(negedge clk);

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_port.md
# serial_port

Memory-mapped 8N1 UART responder occupying the 16-byte serial-port window (0xEFF0–0xEFFF) of the 6502-style CPU bus. The system address decoder asserts `sp_cs` for this window and routes `sp_do` back to the CPU read mux. The block holds small TX and RX FIFOs, a programmable baud divisor, and sticky error flags, and drives and samples the external `txd`/`rxd` pins.

## Interface
- `DEPTH_LOG2`, 2: log2 of the TX and RX FIFO depths (4 entries each).
- `DIV_RESET`, 16'd434: baud divisor after reset, in clocks per bit.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sp_cs`  in  1  chip select from the address decoder.
- `rw`  in  1  bus direction: 1 = write, 0 = read (same encoding as the decoder's).
- `addr`  in  4  register offset, taken from CPU `addr[3:0]`.
- `di`  in  8  CPU write data.
- `sp_do`  out  8  registered read data.
- `txd`  out  1  serial output; idle high.
- `rxd`  in  1  serial input; asynchronous to `clk`.
- `irq`  out  1  level, equal to `rx_avail`.

## Operation
- Register map:
  - 0x0 DATA. Write pushes `di` into the TX FIFO. Read returns the RX FIFO head and pops it.
  - 0x1 STATUS, read-only:
    - bit0 `rx_avail`
    - bit1 `tx_full`
    - bit2 `tx_idle`: TX FIFO empty and no frame in progress
    - bit3 `rx_overrun`: sticky
    - bit4 `frame_err`: sticky
    - bits 7:5 read 0
  - 0x2 DIV_LO and 0x3 DIV_HI: baud divisor, read/write.
  - 0x4–0xF: reads return 0x00; writes are ignored.
- Access qualifiers: an access occurs only when `sp_cs` is high. A write is `sp_cs & rw`; a read is `sp_cs & ~rw`.
- Effective bit period: `max(DIV, 4)` clocks.
- A write to a full TX FIFO is dropped silently.
- A DATA read with the RX FIFO empty returns 0x00 and does not pop.
- Reading STATUS clears `rx_overrun` and `frame_err` after their values are captured into `sp_do`. If a new error event occurs in the same cycle, the flag stays set.
- TX FSM, states IDLE → START → DATA → STOP:
  - IDLE: pops the FIFO when it is non-empty.
  - START: `txd` low for one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP: `txd` high for one bit period.
  - At the end of STOP, go to START directly if the FIFO is non-empty, otherwise to IDLE. There is no extra idle time between back-to-back frames.
- RX path: `rxd` passes through a 2-flop synchronizer, then the RX FSM (IDLE → START → DATA → STOP → WAIT_HIGH).
  - IDLE: a falling edge starts counting.
  - START: at period/2 (integer), re-sample the line. If it is high, treat it as a glitch and return to IDLE.
  - DATA: sample every full period for 8 data bits, LSB first.
  - STOP: sample once.
    - Stop bit = 1 and FIFO not full: push the byte.
    - Stop bit = 1 and FIFO full: drop the byte and set `rx_overrun`.
    - Stop bit = 0: discard the byte, set `frame_err`, and go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE once the synchronized `rxd` is 1.
- A DIV write takes effect at the next frame start. A frame already in progress keeps its divisor.

## Timing
- Reset values: `sp_do` = 0x00, `txd` = 1, `irq` = 0, both FIFOs empty, flags 0, DIV = `DIV_RESET`, both FSMs in IDLE.
- Reset is asynchronous. Asserting it mid-frame forces `txd` high immediately and aborts any RX frame.
- Read latency is 1 cycle. On any read, `sp_do` is updated at the edge ending the read cycle. At all other times `sp_do` holds its value.
- A DATA pop happens at that same edge, and `rx_avail`/`irq` fall at that edge if the FIFO empties.
- TX launch: a write at edge E lands in the FIFO. The FSM pops it at E+1. `txd` falls at E+2, so the start bit begins 2 clocks after the write.
- RX capture: a byte is pushed 3 clocks after the synchronized stop-bit sample point (2 synchronizer flops plus the push). `rx_avail` rises at that push edge.
- A simultaneous FIFO push and pop is legal at any fill level except "pop when empty".

## Structure
- Package `serial_port_pkg` holds:
  - register offset localparams: `REG_DATA`, `REG_STATUS`, `REG_DIV_LO`, `REG_DIV_HI`
  - STATUS bit-index constants
  - `tx_state_t` and `rx_state_t` enums
  - `MIN_DIV` = 4
- Sub-module `sync_fifo` (parameter `DEPTH_LOG2`, 8-bit data, `push`/`pop`/`full`/`empty`/`dout` first-word-fall-through) is instantiated twice, once for TX and once for RX.

## Test plan
- Reset then read STATUS → `sp_do` = 0x04 one cycle later; `txd` = 1; DIV reads back 0xB2/0x01.
- DIV = 8; write 0xA5 to DATA → `txd` falls 2 clocks later, then the frame is 0, 1,0,1,0,0,1,0,1, 1 at 8 clocks per bit; `tx_idle` returns to 1 after 80 clocks.
- Write 5 bytes back-to-back with TX busy → the 5th is dropped; 4 contiguous frames are sent with no gap; `tx_full` is observed high.
- DIV = 8; drive the frame 0x3C on `rxd` → `irq` rises; DATA read returns 0x3C; `irq` falls at the edge of the read.
- Send 5 frames without reading → STATUS = 0x0D; a second STATUS read returns 0x05; DATA reads return the first 4 bytes in order.
- Send a frame with stop bit = 0, and separately a 2-clock low glitch → `frame_err` is set for the bad frame and nothing is pushed; the glitch yields no byte and no flag; asserting `reset` mid-frame forces `txd` = 1 and empties both FIFOs.
